lut_requester: RTL and testbench

LUT_REQUESTER -- requirements
Module: lut_requester

---
 rtl/lut_req_pkg.sv | 9 +
 rtl/lut_rsp_fifo.sv | 40 ++++
 rtl/lut_requester.sv | 79 +++++++
 tb/tb_lut_requester.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_req_pkg.sv
// lut_req_pkg: shared widths and limits for the LUT requester slice.
package lut_req_pkg;
    localparam int LUT_ADDR_W  = 8;
    localparam int LUT_DATA_W  = 32;
    localparam int LUT_MAX_LAT = 4;
    localparam int INF_W       = $clog2(LUT_MAX_LAT + 1);
    typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
    typedef logic [LUT_DATA_W-1:0] lut_data_t;
endpackage

// File: rtl/lut_rsp_fifo.sv
// lut_rsp_fifo: circular response FIFO; head is zero when empty.
module lut_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic do_pop;
    assign empty  = count == '0;
    assign full   = count == CW'(DEPTH);
    assign do_pop = pop & ~empty;
    assign dout   = empty ? '0 : mem[rd];
    always_ff @(posedge clk) begin
        if (push) mem[wr] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (do_pop) rd <= rd + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
            assert (!(push && full && !do_pop));
        end
    end
endmodule

// File: rtl/lut_requester.sv
// lut_requester: credit-gated LUT lookups with a fixed-latency responder and in-order response FIFO.
// Optional LUT_REQ_STATS_EN adds saturating stall_cnt / lookup_cnt outputs.
module lut_requester
    import lut_req_pkg::*;
#(
    parameter int LAT   = 1,
    parameter int DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  req_valid,
    input  logic [LUT_ADDR_W-1:0] req_addr,
    output logic                  req_ready,
    output logic                  TIE_lut_Out_Req,
    output logic [LUT_ADDR_W-1:0] TIE_lut_Out,
    input  logic                  TIE_lut_Rdy,
    input  logic [LUT_DATA_W-1:0] TIE_lut_In,
    output logic                  rsp_valid,
    output logic [LUT_DATA_W-1:0] rsp_data,
    input  logic                  rsp_ready,
`ifdef LUT_REQ_STATS_EN
    output logic [15:0]           stall_cnt,
    output logic [15:0]           lookup_cnt,
`endif
    output logic                  busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = 8;
    logic [LAT-1:0] pend;
    logic [INF_W-1:0] inflight;
    logic [CW-1:0] count;
    logic [SW-1:0] used;
    lut_data_t head;
    logic full, empty, credit, acc, exit_bit, pop;
    // Credit reserves a FIFO slot at acceptance, so a capture can never find the FIFO full.
    assign used            = SW'(inflight) + SW'(count);
    assign credit          = used < SW'(DEPTH);
    assign TIE_lut_Out_Req = req_valid & credit & ~Reset;
    assign TIE_lut_Out     = req_addr;
    assign req_ready       = credit & TIE_lut_Rdy & ~Reset;
    assign acc             = req_valid & req_ready;
    assign exit_bit        = pend[LAT-1];
    assign rsp_valid       = ~empty & ~Reset;
    assign rsp_data        = Reset ? '0 : head;
    assign pop             = rsp_valid & rsp_ready;
    assign busy            = ~Reset & ((inflight != '0) | ~empty);
    always_ff @(posedge CLK) begin
        if (Reset) begin
            pend     <= '0;
            inflight <= '0;
        end else begin
            pend     <= LAT'({pend, acc});
            inflight <= inflight + INF_W'(acc) - INF_W'(exit_bit);
            assert (!(exit_bit && full && !pop));
        end
    end
    lut_rsp_fifo #(.DEPTH(DEPTH), .WIDTH(LUT_DATA_W)) u_fifo (
        .clk   (CLK),
        .rst   (Reset),
        .push  (exit_bit),
        .pop   (pop),
        .din   (TIE_lut_In),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
`ifdef LUT_REQ_STATS_EN
    always_ff @(posedge CLK) begin
        if (Reset) begin
            stall_cnt  <= '0;
            lookup_cnt <= '0;
        end else begin
            if (TIE_lut_Out_Req && !TIE_lut_Rdy && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
            if (acc && lookup_cnt != 16'hFFFF) lookup_cnt <= lookup_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_lut_requester.sv
// tb_lut_requester: directed checks of two requester instances (LAT=1 and LAT=2, DEPTH=4).
module tb_lut_requester;
    logic clk;
    logic r1, v1, rr1, oreq1, rdy1, rv1, rsr1, busy1;
    logic r2, v2, rr2, oreq2, rdy2, rv2, rsr2, busy2;
    logic [7:0] a1, oaddr1, a2, oaddr2;
    logic [31:0] tin1, rd1, tin2, rd2, d1, d2a, d2b;
`ifdef LUT_REQ_STATS_EN
    logic [15:0] stall1, look1, stall2, look2;
`endif
    int tests = 0;
    int fails = 0;

    lut_requester #(.LAT(1), .DEPTH(4)) dut1 (
        .CLK(clk), .Reset(r1), .req_valid(v1), .req_addr(a1), .req_ready(rr1),
        .TIE_lut_Out_Req(oreq1), .TIE_lut_Out(oaddr1), .TIE_lut_Rdy(rdy1), .TIE_lut_In(tin1),
        .rsp_valid(rv1), .rsp_data(rd1), .rsp_ready(rsr1),
`ifdef LUT_REQ_STATS_EN
        .stall_cnt(stall1), .lookup_cnt(look1),
`endif
        .busy(busy1));

    lut_requester #(.LAT(2), .DEPTH(4)) dut2 (
        .CLK(clk), .Reset(r2), .req_valid(v2), .req_addr(a2), .req_ready(rr2),
        .TIE_lut_Out_Req(oreq2), .TIE_lut_Out(oaddr2), .TIE_lut_Rdy(rdy2), .TIE_lut_In(tin2),
        .rsp_valid(rv2), .rsp_data(rd2), .rsp_ready(rsr2),
`ifdef LUT_REQ_STATS_EN
        .stall_cnt(stall2), .lookup_cnt(look2),
`endif
        .busy(busy2));

    function automatic logic [31:0] f(input logic [7:0] a);
        return {8'hC0, a, ~a, a + 8'h11};
    endfunction

    // Responder model: data for an accepted address appears LAT cycles later.
    always @(posedge clk) begin
        d1  <= (v1 && rr1) ? f(a1) : 32'h0;
        d2a <= (v2 && rr2) ? f(a2) : 32'h0;
        d2b <= d2a;
    end
    assign tin1 = d1;
    assign tin2 = d2b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    int n, acc_n, pop_n, stalled;
    logic [7:0] na;

    initial begin
        r1 = 1; r2 = 1; v1 = 1; a1 = 8'h33; rdy1 = 1; rsr1 = 0;
        v2 = 0; a2 = 0; rdy2 = 1; rsr2 = 0;
        tick; tick; #2;
        chk("rst_oreq", oreq1, 0);
        chk("rst_ready", rr1, 0);
        chk("rst_rvalid", rv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_rdata", rd1, 0);
        chk("rst_rvalid2", rv2, 0);
        chk("rst_busy2", busy2, 0);
`ifdef LUT_REQ_STATS_EN
        chk("rst_stall", stall1, 0);
        chk("rst_lookup", look1, 0);
`endif
        r1 = 0; r2 = 0; v1 = 0;
        tick;
        // Back-to-back lookups, LAT=1: response k visible two cycles after its acceptance.
        rsr1 = 1;
        for (int k = 0; k < 11; k++) begin
            v1 = k < 8;
            a1 = 8'(k);
            #2;
            if (k < 8) chk("b2b_ready", rr1, 1);
            chk("b2b_rvalid", rv1, (k >= 2 && k <= 9) ? 1 : 0);
            if (k >= 2 && k <= 9) chk("b2b_rdata", rd1, f(8'(k - 2)));
            tick;
        end
        #2;
        chk("b2b_idle_rvalid", rv1, 0);
        chk("b2b_idle_busy", busy1, 0);
        tick;
        // Responder stall with address held.
        rdy1 = 0; v1 = 1; a1 = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_oreq", oreq1, 1);
            chk("stall_oaddr", oaddr1, 8'h5A);
            chk("stall_ready", rr1, 0);
            tick;
        end
        rdy1 = 1;
        #2;
        chk("stall_release_ready", rr1, 1);
        tick;
        v1 = 0;
        #2;
        chk("stall_pend_rvalid", rv1, 0);
        chk("stall_pend_busy", busy1, 1);
        tick;
        #2;
        chk("stall_rvalid", rv1, 1);
        chk("stall_rdata", rd1, f(8'h5A));
        tick;
        #2;
        chk("stall_single_rvalid", rv1, 0);
        chk("stall_single_busy", busy1, 0);
`ifdef LUT_REQ_STATS_EN
        chk("stall_cnt", stall1, 3);
        chk("lookup_cnt", look1, 9);
`endif
        tick;
        // Scoreboard run: fill FIFO, then alternate pops while requests keep coming.
        acc_n = 0; pop_n = 0; stalled = 0; na = 8'h80;
        for (int k = 0; k < 80; k++) begin
            v1 = acc_n < 24;
            a1 = na;
            rsr1 = (k >= 50) || (k >= 8 && (k % 2 == 1));
            #2;
            if (v1 && !rr1) stalled++;
            if (v1 && rr1) begin
                q.push_back(f(a1));
                acc_n++;
                na++;
            end
            if (rv1 && rsr1) begin
                pop_n++;
                if (q.size() != 0) chk("sb_data", rd1, q.pop_front());
                else chk("sb_spurious", rd1, 32'hFFFF_FFFF);
            end
            tick;
        end
        chk("sb_accepts", 32'(acc_n), 24);
        chk("sb_pops", 32'(pop_n), 24);
        chk("sb_left", 32'(q.size()), 0);
        chk("sb_backpressure", (stalled != 0) ? 1 : 0, 1);
        // LAT=2, DEPTH=4, no pops: credit admits exactly four.
        rsr2 = 0; na = 8'h40; n = 0;
        for (int k = 0; k < 10; k++) begin
            v2 = 1;
            a2 = na;
            #2;
            if (rr2) begin
                n++;
                na++;
            end
            tick;
        end
        a2 = na;
        chk("cap_accepts", 32'(n), 4);
        #2;
        chk("cap_ready_low", rr2, 0);
        chk("cap_oreq_low", oreq2, 0);
        rsr2 = 1;
        #1;
        chk("cap_head_valid", rv2, 1);
        chk("cap_head_data", rd2, f(8'h40));
        tick;
        rsr2 = 0; n = 0;
        for (int k = 0; k < 6; k++) begin
            a2 = na;
            #2;
            if (rr2) begin
                n++;
                na++;
            end
            tick;
        end
        chk("cap_one_more", 32'(n), 1);
        // Reset with two lookups in flight and one FIFO entry.
        v2 = 0; r2 = 1;
        tick;
        r2 = 0;
        tick;
        v2 = 1;
        for (int k = 0; k < 3; k++) begin
            a2 = 8'(8'h90 + k);
            #2;
            chk("flush_accept", rr2, 1);
            tick;
        end
        v2 = 0;
        #1;
        chk("flush_pre_rvalid", rv2, 1);
        chk("flush_pre_busy", busy2, 1);
        r2 = 1;
        #1;
        chk("flush_in_rvalid", rv2, 0);
        chk("flush_in_busy", busy2, 0);
        tick;
        r2 = 0;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("flush_rvalid", rv2, 0);
            chk("flush_busy", busy2, 0);
            chk("flush_rdata", rd2, 0);
            tick;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
